// File: rtl/fsm_seq_arbiter.sv
// Round-robin front end that time-shares one external fsm between NUM_REQ job sources.
// Each granted job resets the fsm, plays its stored {q1,q2} symbols, samples count and reports a hit.
module fsm_seq_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_STEPS = 8,
  parameter int STEP_W    = $clog2(MAX_STEPS + 1),
  parameter int CNT_W     = 16,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int SEQ_W    = 2 * MAX_STEPS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*SEQ_W-1:0]    seq_data,
  input  logic [NUM_REQ*STEP_W-1:0]   seq_len,
  input  logic                        hit_clr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        busy,
  output logic                        done,
  output logic [ID_W-1:0]             done_id,
  output logic                        hit,
  output logic [CNT_W-1:0]            hit_cnt,
  output logic                        fsm_reset,
  output logic                        fsm_q1,
  output logic                        fsm_q2,
  input  logic [1:0]                  fsm_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_RST,
    S_PLAY,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [STEP_W-1:0] MAX_LEN = STEP_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [STEP_W-1:0]   r_len;
  logic [SEQ_W-1:0]    r_seq;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_winner;
  logic                r_hit_next;

  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_busy;
  logic                r_done;
  logic [ID_W-1:0]     r_done_id;
  logic                r_hit;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic                r_fsm_reset;
  logic [1:0]          r_fsm_q;

  logic [2*NUM_REQ-1:0] w_req_rot;
  logic                 w_any_req;
  logic [ID_W-1:0]      w_winner;
  logic [SEQ_W-1:0]     w_seq_sel;
  logic [STEP_W-1:0]    w_len_raw;
  logic [STEP_W-1:0]    w_len_clamped;
  logic [1:0]           w_sym;
  logic                 w_fsm_reset_nxt;
  logic [1:0]           w_fsm_q_nxt;
  logic [ID_W-1:0]      w_ptr_nxt;

  // Rotating the request vector by rr_ptr turns the circular scan into a plain lowest-index search.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    w_req_rot = {req, req} >> r_rr_ptr;
    w_any_req = 1'b0;
    w_winner  = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any_req && w_req_rot[k]) begin
        w_any_req = 1'b1;
        w_winner  = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_seq_sel     = SEQ_W'(seq_data >> (int'(w_winner) * SEQ_W));
  assign w_len_raw     = STEP_W'(seq_len >> (int'(w_winner) * STEP_W));
  assign w_len_clamped = (w_len_raw > MAX_LEN) ? MAX_LEN : w_len_raw;
  assign w_ptr_nxt     = (r_winner == ID_W'(NUM_REQ - 1)) ? '0 : r_winner + ID_W'(1);

  // Next-state and next-output decode; outputs are registered from the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_GRANT_RST;
      end
      S_GRANT_RST: begin
        w_step_nxt  = '0;
        w_state_nxt = (r_len == '0) ? S_SAMPLE : S_PLAY;
      end
      S_PLAY: begin
        if (r_step == r_len - STEP_W'(1)) w_state_nxt = S_SAMPLE;
        else                              w_step_nxt  = r_step + STEP_W'(1);
      end
      S_SAMPLE: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_sym           = 2'(r_seq >> {w_step_nxt, 1'b0});
    w_fsm_reset_nxt = (w_state_nxt == S_GRANT_RST);
    w_fsm_q_nxt     = (w_state_nxt == S_PLAY) ? w_sym : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the latched job buffer is reset too; it is only a few flops and keeps playout values defined.
      r_seq       <= '0;
      r_len       <= '0;
      r_winner    <= '0;
      r_rr_ptr    <= '0;
      r_hit_next  <= 1'b0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_hit       <= 1'b0;
      r_fsm_reset <= 1'b1;
      r_fsm_q     <= 2'b00;
    end else begin
      r_done      <= 1'b0;
      r_fsm_reset <= w_fsm_reset_nxt;
      r_fsm_q     <= w_fsm_q_nxt;

      if (r_state == S_IDLE && w_any_req) begin
        r_seq    <= w_seq_sel;
        r_len    <= w_len_clamped;
        r_winner <= w_winner;
        r_gnt    <= NUM_REQ'(1) << w_winner;
        r_busy   <= 1'b1;
      end

      if (r_state == S_SAMPLE) r_hit_next <= (fsm_count == 2'b11);

      if (r_state == S_DONE) begin
        r_done    <= 1'b1;
        r_done_id <= r_winner;
        r_hit     <= r_hit_next;
        r_gnt     <= '0;
        r_busy    <= 1'b0;
        r_rr_ptr  <= w_ptr_nxt;
      end
    end
  end

  // A clear arriving with a hit completion takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt <= '0;
    end else if (hit_clr) begin
      r_hit_cnt <= '0;
    end else if (r_state == S_DONE && r_hit_next && r_hit_cnt != CNT_MAX) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign hit       = r_hit;
  assign hit_cnt   = r_hit_cnt;
  assign fsm_reset = r_fsm_reset;
  assign fsm_q1    = r_fsm_q[1];
  assign fsm_q2    = r_fsm_q[0];

endmodule
